// File: rtl/spi_slave_framed.sv
// Framed SPI slave: synchronised pins, configurable width/mode/bit order,
// one-deep transmit buffer with load handshake, underrun and abort reporting.
module spi_slave_framed #(
    parameter int DATA_WIDTH  = 16,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter bit LSB_FIRST   = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  cs_bar,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_done,
    output logic                  tx_underrun,
    output logic                  frame_error
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                  state, state_next;
    logic [SYNC_STAGES-1:0]  sclk_sync, cs_sync, mosi_sync;
    logic                    sclk_d, cs_d;
    logic [CW-1:0]           bit_cnt;
    logic [DATA_WIDTH-1:0]   rx_shift, tx_shift, tx_buf;
    logic                    tx_full, miso_q;
    logic                    word_start, word_done, abort;

    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
        return LSB_FIRST ? w[0] : w[DATA_WIDTH-1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] w);
        return LSB_FIRST ? (w >> 1) : (w << 1);
    endfunction

    // Sync chains reset to the idle pin levels so release of reset creates no edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync <= {SYNC_STAGES{CPOL}};
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= CPOL;
            cs_d      <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling its pre-edge input.
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_bar};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            cs_d      <= cs_sync[SYNC_STAGES-1];
        end
    end

    logic sclk_s, cs_s, mosi_s;
    logic lead_edge, trail_edge, sample_edge, drive_edge, cs_fall, cs_rise;
    logic [DATA_WIDTH-1:0] rx_next, tx_word;

    assign sclk_s     = sclk_sync[SYNC_STAGES-1];
    assign cs_s       = cs_sync[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync[SYNC_STAGES-1];
    assign lead_edge  = (sclk_d == CPOL) && (sclk_s != CPOL);
    assign trail_edge = (sclk_d != CPOL) && (sclk_s == CPOL);
    assign cs_fall    = cs_d && !cs_s;
    assign cs_rise    = !cs_d && cs_s;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    // In mode CPHA=0 the first bit is already on miso, so the trailing edge right
    // after a word boundary must not advance the new word.
    assign drive_edge  = CPHA ? lead_edge : (trail_edge && (bit_cnt != '0));
    assign rx_next = LSB_FIRST ? {mosi_s, rx_shift[DATA_WIDTH-1:1]}
                               : {rx_shift[DATA_WIDTH-2:0], mosi_s};
    assign tx_word = tx_full ? tx_buf : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        state_next = state;
        word_start = 1'b0;
        word_done  = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_next = SHIFT;
                    word_start = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_next = IDLE;
                    abort      = (bit_cnt != '0);
                end else if (sample_edge && bit_cnt == LAST_BIT) begin
                    word_done  = 1'b1;
                    word_start = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            tx_buf      <= '0;
            tx_full     <= 1'b0;
            miso_q      <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_done     <= 1'b0;
            tx_underrun <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            rx_valid    <= word_done;
            tx_done     <= word_done;
            tx_underrun <= word_start && !tx_full;
            frame_error <= abort;
            if (word_done) rx_data <= rx_next;

            // A load coinciding with an empty-buffer word start fills the buffer for the next word.
            if (word_start && tx_full) begin
                tx_full <= 1'b0;
            end else if (tx_load && !tx_full) begin
                tx_buf  <= tx_data;
                tx_full <= 1'b1;
            end

            if (state == SHIFT && cs_rise) begin
                bit_cnt  <= '0;
                rx_shift <= '0;
                tx_shift <= '0;
                miso_q   <= 1'b0;
            end else if (word_start) begin
                bit_cnt <= '0;
                if (CPHA) begin
                    tx_shift <= tx_word;
                end else begin
                    miso_q   <= first_bit(tx_word);
                    tx_shift <= advance(tx_word);
                end
            end else if (state == SHIFT) begin
                if (sample_edge) begin
                    rx_shift <= rx_next;
                    bit_cnt  <= bit_cnt + 1'b1;
                end
                if (drive_edge) begin
                    miso_q   <= first_bit(tx_shift);
                    tx_shift <= advance(tx_shift);
                end
            end
        end
    end

    assign tx_ready = !tx_full;
    assign miso_oe  = (state == SHIFT);
    assign miso     = miso_q && (state == SHIFT);

endmodule

// File: tb/tb_spi_slave_framed.sv
// Directed bench: one 16-bit mode-0 MSB-first slave (port 4) plus four 8-bit
// LSB-first slaves covering every CPOL/CPHA combination (ports 0..3).
module tb_spi_slave_framed;

    localparam int HALF = 8;   // clk cycles per SCLK phase

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] sclk_a;
    logic [4:0] cs_a;
    logic       mosi;
    logic [4:0] tx_load_v;
    logic [15:0] tx16;
    logic [7:0]  tx8 [4];

    wire [4:0]  miso_v, miso_oe_v, tx_ready_v, rx_valid_v, tx_done_v, udr_v, ferr_v;
    wire [15:0] rx16;
    wire [7:0]  rx8 [4];

    int n_checks = 0;
    int n_fail   = 0;
    int rxv_cnt [5];
    int done_cnt[5];
    int udr_cnt [5];
    int ferr_cnt[5];

    always #5 clk = ~clk;

    spi_slave_framed #(
        .DATA_WIDTH(16), .CPOL(1'b0), .CPHA(1'b0), .LSB_FIRST(1'b0), .SYNC_STAGES(2)
    ) u_dut (
        .clk(clk), .reset(reset), .sclk(sclk_a[4]), .cs_bar(cs_a[4]), .mosi(mosi),
        .miso(miso_v[4]), .miso_oe(miso_oe_v[4]), .tx_data(tx16), .tx_load(tx_load_v[4]),
        .tx_ready(tx_ready_v[4]), .rx_data(rx16), .rx_valid(rx_valid_v[4]),
        .tx_done(tx_done_v[4]), .tx_underrun(udr_v[4]), .frame_error(ferr_v[4])
    );

    for (genvar g = 0; g < 4; g++) begin : g_mode
        spi_slave_framed #(
            .DATA_WIDTH(8), .CPOL(g >= 2), .CPHA(g % 2 == 1), .LSB_FIRST(1'b1), .SYNC_STAGES(2)
        ) u_dut8 (
            .clk(clk), .reset(reset), .sclk(sclk_a[g]), .cs_bar(cs_a[g]), .mosi(mosi),
            .miso(miso_v[g]), .miso_oe(miso_oe_v[g]), .tx_data(tx8[g]), .tx_load(tx_load_v[g]),
            .tx_ready(tx_ready_v[g]), .rx_data(rx8[g]), .rx_valid(rx_valid_v[g]),
            .tx_done(tx_done_v[g]), .tx_underrun(udr_v[g]), .frame_error(ferr_v[g])
        );
    end

    always @(posedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (rx_valid_v[i]) rxv_cnt[i]  += 1;
            if (tx_done_v[i])  done_cnt[i] += 1;
            if (udr_v[i])      udr_cnt[i]  += 1;
            if (ferr_v[i])     ferr_cnt[i] += 1;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish within 2 ms");
        $fatal(1, "watchdog expired");
    end

    function automatic bit cpol_of(input int p); return (p == 2 || p == 3); endfunction
    function automatic bit cpha_of(input int p); return (p == 1 || p == 3); endfunction
    function automatic bit lsb_of(input int p);  return (p < 4);            endfunction
    function automatic int width_of(input int p); return (p < 4) ? 8 : 16;  endfunction

    function automatic logic [15:0] rx_of(input int p);
        return (p == 4) ? rx16 : {8'h00, rx8[p]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic half_phase();
        repeat (HALF) @(negedge clk);
    endtask

    task automatic load(input int p, input logic [15:0] data);
        @(negedge clk);
        if (p == 4) tx16 = data;
        else        tx8[p] = data[7:0];
        tx_load_v[p] = 1'b1;
        @(negedge clk);
        tx_load_v[p] = 1'b0;
    endtask

    task automatic cs_low(input int p);
        cs_a[p] = 1'b0;
        half_phase();
    endtask

    task automatic cs_high(input int p);
        half_phase();
        cs_a[p] = 1'b1;
        half_phase();
    endtask

    // Plays the master for nbits bits of one word; optionally loads the next tx word after bit 0.
    task automatic xfer_word(input int p, input logic [15:0] send, input int nbits,
                             input bit do_reload, input logic [15:0] reload,
                             output logic [15:0] recv);
        int w;
        int idx;
        bit cpol;
        w    = width_of(p);
        cpol = cpol_of(p);
        recv = '0;
        for (int i = 0; i < nbits; i++) begin
            idx = lsb_of(p) ? i : (w - 1 - i);
            if (!cpha_of(p)) begin
                mosi = send[idx];
                half_phase();
                recv[idx] = miso_v[p];
                sclk_a[p] = !cpol;
                half_phase();
                sclk_a[p] = cpol;
            end else begin
                sclk_a[p] = !cpol;
                mosi = send[idx];
                half_phase();
                recv[idx] = miso_v[p];
                sclk_a[p] = cpol;
                half_phase();
            end
            if (i == 0 && do_reload) load(p, reload);
        end
    endtask

    typedef struct {
        int          p;
        logic [15:0] send;
        logic [15:0] tx;
        logic [15:0] exp_rx;
        logic [15:0] exp_miso;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [15:0] got;
        int rv0, ud0, fe0, dn0;

        reset     = 1'b1;
        sclk_a    = 5'b01100;
        cs_a      = 5'b11111;
        mosi      = 1'b0;
        tx_load_v = '0;
        tx16      = '0;
        for (int i = 0; i < 4; i++) tx8[i] = '0;
        for (int i = 0; i < 5; i++) begin
            rxv_cnt[i] = 0; done_cnt[i] = 0; udr_cnt[i] = 0; ferr_cnt[i] = 0;
        end

        vecs[0] = '{0, 16'h0081, 16'h003C, 16'h0081, 16'h003C};
        vecs[1] = '{1, 16'h0081, 16'h003C, 16'h0081, 16'h003C};
        vecs[2] = '{2, 16'h0081, 16'h003C, 16'h0081, 16'h003C};
        vecs[3] = '{3, 16'h0081, 16'h003C, 16'h0081, 16'h003C};
        vecs[4] = '{4, 16'h1234, 16'hA5C3, 16'h1234, 16'hA5C3};
        vecs[5] = '{4, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
        vecs[6] = '{4, 16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE};

        repeat (3) @(negedge clk);
        check("reset rx_data",   32'(rx16), 32'h0);
        check("reset tx_ready",  32'(tx_ready_v), 32'h1F);
        check("reset miso",      32'(miso_v), 32'h0);
        check("reset miso_oe",   32'(miso_oe_v), 32'h0);
        check("reset pulses",    32'({rx_valid_v, tx_done_v, udr_v, ferr_v}), 32'h0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Table: single-word frames on every port/mode.
        foreach (vecs[k]) begin
            rv0 = rxv_cnt[vecs[k].p];
            fe0 = ferr_cnt[vecs[k].p];
            load(vecs[k].p, vecs[k].tx);
            cs_low(vecs[k].p);
            check($sformatf("vec%0d miso_oe", k), 32'(miso_oe_v[vecs[k].p]), 32'h1);
            xfer_word(vecs[k].p, vecs[k].send, width_of(vecs[k].p), 1'b0, 16'h0, got);
            cs_high(vecs[k].p);
            check($sformatf("vec%0d rx_data", k), 32'(rx_of(vecs[k].p)), 32'(vecs[k].exp_rx));
            check($sformatf("vec%0d master rx", k), 32'(got), 32'(vecs[k].exp_miso));
            check($sformatf("vec%0d rx_valid pulses", k), rxv_cnt[vecs[k].p] - rv0, 32'd1);
            check($sformatf("vec%0d frame_error", k), ferr_cnt[vecs[k].p] - fe0, 32'd0);
            check($sformatf("vec%0d tx_ready", k), 32'(tx_ready_v[vecs[k].p]), 32'h1);
        end

        // Back-to-back burst with the next tx word loaded during each word.
        rv0 = rxv_cnt[4]; ud0 = udr_cnt[4]; dn0 = done_cnt[4];
        load(4, 16'h1111);
        cs_low(4);
        xfer_word(4, 16'h0001, 16, 1'b1, 16'h2222, got);
        check("burst w1 master rx", 32'(got), 32'h1111);
        check("burst w1 rx_data", 32'(rx16), 32'h0001);
        xfer_word(4, 16'h0002, 16, 1'b1, 16'h3333, got);
        check("burst w2 master rx", 32'(got), 32'h2222);
        check("burst w2 rx_data", 32'(rx16), 32'h0002);
        xfer_word(4, 16'h0003, 16, 1'b1, 16'h4444, got);
        check("burst w3 master rx", 32'(got), 32'h3333);
        cs_high(4);
        check("burst rx_data", 32'(rx16), 32'h0003);
        check("burst rx_valid pulses", rxv_cnt[4] - rv0, 32'd3);
        check("burst tx_done pulses", done_cnt[4] - dn0, 32'd3);
        check("burst underruns", udr_cnt[4] - ud0, 32'd0);

        // Underrun: word starts with the buffer empty, both at cs fall and at word end.
        ud0 = udr_cnt[4];
        cs_low(4);
        check("underrun at start", udr_cnt[4] - ud0, 32'd1);
        xfer_word(4, 16'hBEEF, 16, 1'b0, 16'h0, got);
        cs_high(4);
        check("underrun master rx", 32'(got), 32'h0000);
        check("underrun count", udr_cnt[4] - ud0, 32'd2);
        check("underrun rx_data", 32'(rx16), 32'hBEEF);
        check("idle miso", 32'({miso_v[4], miso_oe_v[4]}), 32'h0);

        // Load while full is ignored.
        load(4, 16'h1357);
        check("full tx_ready", 32'(tx_ready_v[4]), 32'h0);
        load(4, 16'h2468);
        cs_low(4);
        xfer_word(4, 16'h0F0F, 16, 1'b0, 16'h0, got);
        cs_high(4);
        check("ignored load master rx", 32'(got), 32'h1357);
        check("ignored load rx_data", 32'(rx16), 32'h0F0F);

        // Abort after 7 of 16 bits; buffer reloaded mid-word must survive.
        rv0 = rxv_cnt[4]; fe0 = ferr_cnt[4];
        load(4, 16'h5A5A);
        cs_low(4);
        xfer_word(4, 16'hFFFF, 7, 1'b1, 16'hC0DE, got);
        cs_high(4);
        check("abort frame_error", ferr_cnt[4] - fe0, 32'd1);
        check("abort rx_valid", rxv_cnt[4] - rv0, 32'd0);
        check("abort rx_data kept", 32'(rx16), 32'h0F0F);
        check("abort buffer kept", 32'(tx_ready_v[4]), 32'h0);
        cs_low(4);
        xfer_word(4, 16'h6789, 16, 1'b0, 16'h0, got);
        cs_high(4);
        check("post-abort rx_data", 32'(rx16), 32'h6789);
        check("post-abort master rx", 32'(got), 32'hC0DE);
        check("post-abort frame_error", ferr_cnt[4] - fe0, 32'd1);

        // Reset after 9 bits, with a word waiting in the buffer.
        load(4, 16'h1111);
        cs_low(4);
        xfer_word(4, 16'hFFFF, 9, 1'b1, 16'h9999, got);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid reset rx_data", 32'(rx16), 32'h0);
        check("mid reset tx_ready", 32'(tx_ready_v[4]), 32'h1);
        check("mid reset miso", 32'({miso_v[4], miso_oe_v[4]}), 32'h0);
        check("mid reset pulses", 32'({rx_valid_v[4], tx_done_v[4], udr_v[4], ferr_v[4]}), 32'h0);
        cs_a[4]   = 1'b1;
        sclk_a[4] = 1'b0;
        half_phase();
        reset = 1'b0;
        half_phase();
        rv0 = rxv_cnt[4];
        load(4, 16'h4321);
        cs_low(4);
        xfer_word(4, 16'h0ACE, 16, 1'b0, 16'h0, got);
        cs_high(4);
        check("post-reset rx_data", 32'(rx16), 32'h0ACE);
        check("post-reset master rx", 32'(got), 32'h4321);
        check("post-reset rx_valid", rxv_cnt[4] - rv0, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
